// File: rtl/obs_pkg.sv
// Shared constants and encodings for the multi-obstacle sprite renderer.
package obs_pkg;

  localparam int unsigned SPR_W_LOG2_DEF = 4;
  localparam int unsigned SPR_H_LOG2_DEF = 4;
  localparam int unsigned TYPE_W_DEF     = 2;
  localparam int unsigned HIT_ID_W       = 3;
  localparam int unsigned GROUND_Y       = 42;

  typedef enum logic [1:0] {
    TYPE_CACTUS_S = 2'd0,
    TYPE_CACTUS_L = 2'd1,
    TYPE_BIRD_UP  = 2'd2,
    TYPE_BIRD_DN  = 2'd3
  } obs_type_e;

  // Coordinate width after down-conversion from the native 10-bit raster.
  function automatic int unsigned coord_w(input int unsigned conv);
    return 10 - conv;
  endfunction

endpackage

// File: rtl/obs_render_if.sv
// Pixel, obstacle-table, sprite-ROM and collision signals of the obstacle renderer.
interface obs_render_if
  import obs_pkg::*;
#(
  parameter int unsigned CONV       = 0,
  parameter int unsigned NUM_OBS    = 3,
  parameter int unsigned SPR_W_LOG2 = SPR_W_LOG2_DEF,
  parameter int unsigned SPR_H_LOG2 = SPR_H_LOG2_DEF,
  parameter int unsigned TYPE_W     = TYPE_W_DEF
);
  localparam int unsigned W  = coord_w(CONV);
  localparam int unsigned AW = TYPE_W + SPR_H_LOG2 + SPR_W_LOG2;

  logic [W-1:0]              i_hpos;
  logic [W-1:0]              i_vpos;
  logic [NUM_OBS*W-1:0]      i_xpos;
  logic [NUM_OBS*W-1:0]      i_ypos;
  logic [NUM_OBS*TYPE_W-1:0] i_type;
  logic [NUM_OBS-1:0]        i_en;
  logic [AW-1:0]             o_rom_addr;
  logic                      i_sprite_color;
  logic                      i_color_dino;
  logic                      i_frame_start;
  logic                      o_color_obs;
  logic [HIT_ID_W-1:0]       o_hit_id;
  logic                      o_collision;

  modport master (
    output i_hpos, i_vpos, i_xpos, i_ypos, i_type, i_en,
    output i_sprite_color, i_color_dino, i_frame_start,
    input  o_rom_addr, o_color_obs, o_hit_id, o_collision
  );

  modport slave (
    input  i_hpos, i_vpos, i_xpos, i_ypos, i_type, i_en,
    input  i_sprite_color, i_color_dino, i_frame_start,
    output o_rom_addr, o_color_obs, o_hit_id, o_collision
  );

endinterface

// File: rtl/obs_hit_lane.sv
// One obstacle lane: registered sprite-relative offsets, enable/type and the box hit test.
module obs_hit_lane #(
  parameter int unsigned W          = 10,
  parameter int unsigned SPR_W_LOG2 = 4,
  parameter int unsigned SPR_H_LOG2 = 4,
  parameter int unsigned TYPE_W     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W-1:0]      hpos,
  input  logic [W-1:0]      vpos,
  input  logic [W-1:0]      xpos,
  input  logic [W-1:0]      ypos,
  input  logic [TYPE_W-1:0] typ,
  input  logic              en,
  output logic [W-1:0]      x_off_r,
  output logic [W-1:0]      y_off_r,
  output logic [TYPE_W-1:0] type_r,
  output logic              hit_c
);
  localparam logic [W-1:0] SPR_W = W'(1 << SPR_W_LOG2);
  localparam logic [W-1:0] SPR_H = W'(1 << SPR_H_LOG2);

  logic en_r;

  // xpos is the right edge, so bias by sprite width to get a 0-based column.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_off_r <= '0;
      y_off_r <= '0;
      type_r  <= '0;
      en_r    <= 1'b0;
    end else begin
      x_off_r <= hpos - xpos + SPR_W;
      y_off_r <= vpos - ypos;
      type_r  <= typ;
      en_r    <= en;
    end
  end

  // Wrapped offsets make off-screen-left columns fall outside the box naturally.
  assign hit_c = en_r && (x_off_r < SPR_W) && (y_off_r < SPR_H);

endmodule

// File: rtl/obs_render_multi.sv
// Multi-lane obstacle renderer: per-lane hit test, lowest-index priority ROM mux,
// registered pixel/hit-id output and a per-frame sticky collision flag.
module obs_render_multi
  import obs_pkg::*;
#(
  parameter int unsigned CONV       = 0,
  parameter int unsigned NUM_OBS    = 3,
  parameter int unsigned SPR_W_LOG2 = SPR_W_LOG2_DEF,
  parameter int unsigned SPR_H_LOG2 = SPR_H_LOG2_DEF,
  parameter int unsigned TYPE_W     = TYPE_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  obs_render_if.slave  bus
);
  localparam int unsigned W  = coord_w(CONV);
  localparam int unsigned AW = TYPE_W + SPR_H_LOG2 + SPR_W_LOG2;

  logic [W-1:0]        x_off_r [NUM_OBS];
  logic [W-1:0]        y_off_r [NUM_OBS];
  logic [TYPE_W-1:0]   type_r  [NUM_OBS];
  logic [NUM_OBS-1:0]  hit_c;
  logic                any_hit_c;
  logic [HIT_ID_W-1:0] sel_c;
  logic [AW-1:0]       rom_addr_c;

  for (genvar k = 0; k < NUM_OBS; k++) begin : g_lane
    obs_hit_lane #(
      .W          (W),
      .SPR_W_LOG2 (SPR_W_LOG2),
      .SPR_H_LOG2 (SPR_H_LOG2),
      .TYPE_W     (TYPE_W)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .hpos    (bus.i_hpos),
      .vpos    (bus.i_vpos),
      .xpos    (bus.i_xpos[k*W +: W]),
      .ypos    (bus.i_ypos[k*W +: W]),
      .typ     (bus.i_type[k*TYPE_W +: TYPE_W]),
      .en      (bus.i_en[k]),
      .x_off_r (x_off_r[k]),
      .y_off_r (y_off_r[k]),
      .type_r  (type_r[k]),
      .hit_c   (hit_c[k])
    );
  end

  // Lowest hitting lane owns the pixel, even where its sprite is transparent.
  always_comb begin
    any_hit_c  = 1'b0;
    sel_c      = '0;
    rom_addr_c = '0;
    for (int k = 0; k < NUM_OBS; k++) begin
      if (hit_c[k] && !any_hit_c) begin
        any_hit_c  = 1'b1;
        sel_c      = HIT_ID_W'(k);
        rom_addr_c = {type_r[k], y_off_r[k][SPR_H_LOG2-1:0], x_off_r[k][SPR_W_LOG2-1:0]};
      end
    end
  end

  assign bus.o_rom_addr = rom_addr_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.o_color_obs <= 1'b0;
      bus.o_hit_id    <= '0;
    end else begin
      bus.o_color_obs <= any_hit_c && bus.i_sprite_color;
      bus.o_hit_id    <= any_hit_c ? sel_c : '0;
    end
  end

  // Set beats the frame-start clear so a hit on the first pixel is not lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.o_collision <= 1'b0;
    end else if (bus.o_color_obs && bus.i_color_dino) begin
      bus.o_collision <= 1'b1;
    end else if (bus.i_frame_start) begin
      bus.o_collision <= 1'b0;
    end
  end

endmodule

// File: tb/tb_obs_render_multi.sv
// Scoreboard bench for obs_render_multi (CONV=0, NUM_OBS=2) against an integer reference model.
module tb_obs_render_multi;
  import obs_pkg::*;

  localparam int NUM = 2;
  localparam int W   = 10;
  localparam int SW  = 16;
  localparam int SH  = 16;

  typedef struct {
    int addr;
    int color;
    int id;
    int coll;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1023:0] rom_bits;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  int lx [NUM];
  int ly [NUM];
  int lt [NUM];
  bit le [NUM];

  bit p_hit      = 1'b0;
  int p_addr     = 0;
  int p_sel      = 0;
  int last_color = 0;
  int coll_m     = 0;

  obs_render_if #(.CONV(0), .NUM_OBS(NUM), .SPR_W_LOG2(4), .SPR_H_LOG2(4), .TYPE_W(2)) bus ();

  obs_render_multi #(.CONV(0), .NUM_OBS(NUM), .SPR_W_LOG2(4), .SPR_H_LOG2(4), .TYPE_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  assign bus.i_sprite_color = rom_bits[bus.o_rom_addr];

  // Reference: pixel is inside lane k's 16x16 box measured back from its right edge.
  function automatic void ref_pix(input int h, input int v, output bit hit, output int sel, output int addr);
    hit = 1'b0; sel = 0; addr = 0;
    for (int k = NUM - 1; k >= 0; k--) begin
      int dx, dy;
      dx = (((h - lx[k] + SW) % 1024) + 1024) % 1024;
      dy = (((v - ly[k]) % 1024) + 1024) % 1024;
      if (le[k] && dx < SW && dy < SH) begin
        hit = 1'b1; sel = k; addr = lt[k] * 256 + dy * 16 + dx;
      end
    end
  endfunction

  task automatic drive(input int h, input int v, input bit rst_v, input bit fs, input bit dino);
    bit hit; int sel; int addr;
    logic [NUM*W-1:0] xv, yv;
    logic [NUM*2-1:0] tv;
    logic [NUM-1:0]   ev;
    exp_t e;
    @(negedge clk);
    for (int k = 0; k < NUM; k++) begin
      xv[k*W +: W] = W'(lx[k]);
      yv[k*W +: W] = W'(ly[k]);
      tv[k*2 +: 2] = 2'(lt[k]);
      ev[k]        = le[k];
    end
    rst               = rst_v;
    bus.i_hpos        = W'(h);
    bus.i_vpos        = W'(v);
    bus.i_xpos        = xv;
    bus.i_ypos        = yv;
    bus.i_type        = tv;
    bus.i_en          = ev;
    bus.i_frame_start = fs;
    bus.i_color_dino  = dino;
    ref_pix(h, v, hit, sel, addr);
    e.addr  = rst_v ? 0 : (hit ? addr : 0);
    e.color = rst_v ? 0 : ((p_hit && rom_bits[p_addr]) ? 1 : 0);
    e.id    = rst_v ? 0 : (p_hit ? p_sel : 0);
    e.coll  = rst_v ? 0 : ((last_color == 1 && dino) ? 1 : (fs ? 0 : coll_m));
    sb_q.push_back(e);
    coll_m     = e.coll;
    last_color = e.color;
    p_hit      = rst_v ? 1'b0 : hit;
    p_addr     = addr;
    p_sel      = sel;
  endtask

  task automatic set_lane(input int k, input int x, input int y, input int t, input bit en);
    lx[k] = x; ly[k] = y; lt[k] = t; le[k] = en;
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d time=%0t", name, act, req, $time);
    end
  endtask

  // Monitor: every output is due one clock after its stimulus was issued.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        chk("rom_addr",  int'(bus.o_rom_addr),  e.addr);
        chk("color_obs", int'(bus.o_color_obs), e.color);
        chk("hit_id",    int'(bus.o_hit_id),    e.id);
        chk("collision", int'(bus.o_collision), e.coll);
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) rom_bits[i*32 +: 32] = $urandom;
    rom_bits[0] = 1'b1;
    for (int k = 0; k < NUM; k++) set_lane(k, 0, 0, 0, 1'b0);
    bus.i_hpos = '0; bus.i_vpos = '0; bus.i_xpos = '0; bus.i_ypos = '0;
    bus.i_type = '0; bus.i_en = '0; bus.i_frame_start = 1'b0; bus.i_color_dino = 1'b0;

    repeat (3) drive(0, 0, 1'b1, 1'b0, 1'b0);

    // Single lane sweep across its full width plus one pixel either side.
    set_lane(0, 100, GROUND_Y, int'(TYPE_CACTUS_S), 1'b1);
    for (int h = 83; h <= 100; h++) drive(h, GROUND_Y, 1'b0, 1'b0, 1'b0);

    // Overlap: lane 0 wins, then lane 1 once lane 0 is disabled.
    set_lane(1, 104, 40, int'(TYPE_BIRD_UP), 1'b1);
    repeat (2) drive(95, 50, 1'b0, 1'b0, 1'b0);
    le[0] = 1'b0;
    repeat (2) drive(95, 50, 1'b0, 1'b0, 1'b0);

    // Disabled lane with the pixel inside its box.
    le[1] = 1'b0;
    repeat (3) drive(90, 45, 1'b0, 1'b0, 1'b0);

    // Left screen edge: partial sprite.
    set_lane(0, 5, GROUND_Y, int'(TYPE_CACTUS_S), 1'b1);
    for (int h = 0; h <= 6; h++) drive(h, GROUND_Y, 1'b0, 1'b0, 1'b0);

    // Collision: set, hold, clear, and set winning over a simultaneous clear.
    set_lane(0, 100, GROUND_Y, int'(TYPE_CACTUS_S), 1'b1);
    repeat (4) drive(84, GROUND_Y, 1'b0, 1'b0, 1'b1);
    repeat (3) drive(200, 200, 1'b0, 1'b0, 1'b0);
    drive(200, 200, 1'b0, 1'b1, 1'b0);
    repeat (2) drive(200, 200, 1'b0, 1'b0, 1'b0);
    repeat (4) drive(84, GROUND_Y, 1'b0, 1'b0, 1'b1);
    drive(84, GROUND_Y, 1'b0, 1'b1, 1'b1);
    repeat (2) drive(84, GROUND_Y, 1'b0, 1'b0, 1'b0);

    // Reset mid-sweep with a hit in flight.
    for (int h = 84; h <= 99; h++) drive(h, GROUND_Y, (h == 90), 1'b0, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 2000; n++) begin
      if (n % 48 == 0) begin
        for (int k = 0; k < NUM; k++)
          set_lane(k, int'($urandom_range(0, 140)), int'($urandom_range(0, 80)),
                   int'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0));
      end
      drive(int'($urandom_range(0, 150)), int'($urandom_range(0, 100)),
            ($urandom_range(0, 199) == 0), ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 1) == 1));
    end

    drive(0, 0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0 pending entries", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
